calc_core: RTL and testbench
============================

# calc_core

Arithmetic and control core of the keypad calculator. It sits between `keypad_driver` and `segment_driver`. It consumes the 5-bit `eBCD` key code on `sw_clk` and detects each key press once. It runs operand/operator entry and evaluates signed integer `+ - * / %`. It drives the 32-bit `fnd_serial` word that `segment_driver` renders on the 6-digit FND.

## Interface
- `MAX_DIGITS`, default 6: maximum digits accepted per operand.
- `RES_MAX`, default 999999: largest displayable result.
- `RES_MIN`, default -99999: smallest displayable result (5 digits plus sign).
- `sw_clk`  in  1: system clock. One clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `eBCD`  in  5: key code. 0–9 are digits. 10 is `+`, 11 is `-`, 12 is `*`, 13 is `/`, 14 is `%`, 15 is `=`. 5'h1F is idle (no key). Other values are treated as idle.
- `fnd_serial`  out  32 (signed): display word. A decimal value, or one of these codes: `'h00EE_0000` error, `'h0010_0000` PLUS, `'h0020_0000` MINUS, `'h0030_0000` MULTIPLE, `'h0040_0000` DIVID, `'h0050_0000` MODULO, `'h00A0_0000` HAPPY.
- `err`  out  1: high while in state ERR.

## Operation
- **Key event detection**
  - `prev_key` register holds the previous `eBCD`.
  - An event fires when the current `eBCD` is non-idle and `prev_key` is idle.
  - A held key produces exactly one event.
  - A direct key-to-key change with no idle between produces no event.
- **Registers:** signed 32-bit `A`, `B`, `res`; 3-bit `op`; 3-bit `digits`.
- **States:** IDLE, ENTER_A, OP, ENTER_B, RESULT, ERR.
- **IDLE** (after reset): `fnd_serial` = HAPPY.
  - Digit d: A=d, digits=1, go to ENTER_A.
  - Operator or `=`: ignored.
- **ENTER_A**
  - Digit: if digits < MAX_DIGITS, then A = A*10 + d and digits++. Otherwise the digit is ignored.
  - Operator: latch `op`, go to OP.
  - `=`: res = A, go to RESULT.
- **OP:** display the operator code.
  - Digit d: B=d, digits=1, go to ENTER_B.
  - Operator: replaces `op`.
  - `=`: ignored.
- **ENTER_B**
  - Digit: append, same rule as ENTER_A.
  - Operator: ignored.
  - `=`: evaluate.
    - If the result is in range: go to RESULT.
    - Otherwise: go to ERR.
- **RESULT**
  - Digit d: A=d, digits=1, go to ENTER_A.
  - Operator: A = res, latch `op`, go to OP (chaining; a negative A is allowed).
  - `=`: ignored.
- **ERR**
  - Digit d: A=d, digits=1, go to ENTER_A.
  - Other keys: ignored.
- **Display:** `fnd_serial` = A in ENTER_A, B in ENTER_B, res in RESULT, the error code in ERR.
- **Arithmetic:**
  - A×B is computed at 64-bit width.
  - `/` truncates toward zero; `%` takes the sign of the dividend (Verilog signed semantics).
  - B == 0 with `/` or `%` goes to ERR.
  - A result outside [RES_MIN, RES_MAX] goes to ERR.
  - Evaluation is combinational, single cycle; it is acceptable at `sw_clk` rates.

## Timing
- **Reset:**
  - Outputs: `fnd_serial` = `'h00A0_0000`, `err` = 0.
  - Registers: `prev_key` = 5'h1F, A = B = res = 0, op = 0, digits = 0, state = IDLE.
  - Reset is taken at the next edge while `rst` = 1, and overrides any event on that edge.
  - Reset mid-entry discards all operands.
- **Latency:** an event detected at edge k updates the state, registers, `fnd_serial` and `err` at that same edge k. The new values are visible immediately after k.
- `prev_key` updates on every edge.
- Outputs are registered only; no combinational path from `eBCD` to the outputs.
- The 7th digit event leaves `fnd_serial` unchanged.

## Test plan
- Reset, then press 1, 2, `+`, 3, 4, `=`, each held for 3 cycles with 5 idle cycles between. Required sequence: `fnd_serial` goes HAPPY → 1 → 12 → `'h0010_0000` → 3 → 34 → 46, and `err` stays 0.
- Press 3, `-`, 8, `=`: result -5. Then `*`, 2, `=`: display `'h0030_0000`, then 2, then -10 (chained).
- Press 7, `/`, 0, `=`: `'h00EE_0000` and `err` = 1. Then 5: display 5 and `err` = 0.
- Press 9 seven times, then `*`, 2, `=`: display 999999 after the 6th press, unchanged after the 7th, then ERR (product 1999998).
- Hold key 4 for 20 cycles: exactly one digit is appended (display 4, not 44). Then change `eBCD` from 4 directly to 5: no event.
- Press -7 via `0 - 7 =` then `% 3 =`: -7 then -1. Then assert `rst` during entry of `12`: next edge gives HAPPY and state IDLE.

Source files
------------

// File: rtl/calc_core.sv
// ============================================================================
// calc_core : keypad calculator core (key events, operand entry, + - * / %)
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module calc_core #(
   parameter int MAX_DIGITS = 6,
   parameter int RES_MAX    = 999999,
   parameter int RES_MIN    = -99999
) (
   input  logic               sw_clk,
   input  logic               rst,
   input  logic [4:0]         eBCD,
   output logic signed [31:0] fnd_serial,
   output logic               err
);

   localparam logic [4:0]         KEY_IDLE   = 5'h1F;
   localparam logic [2:0]         MAX_D      = 3'(MAX_DIGITS);
   localparam logic signed [63:0] RES_MAX_W  = 64'(RES_MAX);
   localparam logic signed [63:0] RES_MIN_W  = 64'(RES_MIN);
   localparam logic signed [31:0] CODE_ERR   = 32'sh00EE_0000;
   localparam logic signed [31:0] CODE_HAPPY = 32'sh00A0_0000;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTER_A = 3'd1,
      S_OP      = 3'd2,
      S_ENTER_B = 3'd3,
      S_RESULT  = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   state_t             state;
   logic [4:0]         prev_key;
   logic signed [31:0] a;
   logic signed [31:0] b;
   logic signed [31:0] res;
   logic [2:0]         op;
   logic [2:0]         digits;

   // Codes above 15 (not just 5'h1F) count as "no key" on both sides of the edge test.
   logic key_valid;
   logic prev_valid;
   logic key_event;
   logic is_digit;
   logic is_op;
   logic signed [31:0] digit_val;
   logic [2:0]         key_op;
   logic               can_append;
   logic signed [31:0] a_append;
   logic signed [31:0] b_append;

   assign key_valid  = (eBCD <= 5'd15);
   assign prev_valid = (prev_key <= 5'd15);
   assign key_event  = key_valid && !prev_valid;
   assign is_digit   = (eBCD <= 5'd9);
   assign is_op      = (eBCD >= 5'd10) && (eBCD <= 5'd14);
   assign digit_val  = {28'd0, eBCD[3:0]};
   assign key_op     = eBCD[2:0] - 3'd2;
   assign can_append = (digits < MAX_D);
   assign a_append   = (a * 32'sd10) + digit_val;
   assign b_append   = (b * 32'sd10) + digit_val;

   function automatic logic signed [31:0] op_code(input logic [2:0] o);
      case (o)
         OP_ADD:  op_code = 32'sh0010_0000;
         OP_SUB:  op_code = 32'sh0020_0000;
         OP_MUL:  op_code = 32'sh0030_0000;
         OP_DIV:  op_code = 32'sh0040_0000;
         OP_MOD:  op_code = 32'sh0050_0000;
         default: op_code = CODE_ERR;
      endcase
   endfunction

   // Evaluation at 64 bits so a product of two 6-digit operands cannot wrap.
   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] eval_res;
   logic               b_zero;
   logic               div_by_zero;
   logic               eval_ok;
   logic signed [31:0] eval_res32;

   assign a_ext       = {{32{a[31]}}, a};
   assign b_ext       = {{32{b[31]}}, b};
   assign b_zero      = (b == 32'sd0);
   assign div_by_zero = b_zero && ((op == OP_DIV) || (op == OP_MOD));

   always_comb begin
      eval_res = a_ext + b_ext;
      case (op)
         OP_SUB:  eval_res = a_ext - b_ext;
         OP_MUL:  eval_res = a_ext * b_ext;
         OP_DIV:  eval_res = b_zero ? 64'sd0 : (a_ext / b_ext);
         OP_MOD:  eval_res = b_zero ? 64'sd0 : (a_ext % b_ext);
         default: eval_res = a_ext + b_ext;
      endcase
   end

   assign eval_ok    = !div_by_zero && (eval_res <= RES_MAX_W) && (eval_res >= RES_MIN_W);
   assign eval_res32 = eval_res[31:0];

   always_ff @(posedge sw_clk) begin
      if (rst) begin
         state      <= S_IDLE;
         prev_key   <= KEY_IDLE;
         a          <= 32'sd0;
         b          <= 32'sd0;
         res        <= 32'sd0;
         op         <= 3'd0;
         digits     <= 3'd0;
         fnd_serial <= CODE_HAPPY;
         err        <= 1'b0;
      end else begin
         prev_key <= eBCD;
         if (key_event) begin
            case (state)
               S_IDLE: begin
                  if (is_digit) begin
                     a          <= digit_val;
                     digits     <= 3'd1;
                     state      <= S_ENTER_A;
                     fnd_serial <= digit_val;
                  end
               end

               S_ENTER_A: begin
                  if (is_digit) begin
                     if (can_append) begin
                        a          <= a_append;
                        digits     <= digits + 3'd1;
                        fnd_serial <= a_append;
                     end
                  end else if (is_op) begin
                     op         <= key_op;
                     state      <= S_OP;
                     fnd_serial <= op_code(key_op);
                  end else begin
                     res        <= a;
                     state      <= S_RESULT;
                     fnd_serial <= a;
                  end
               end

               S_OP: begin
                  if (is_digit) begin
                     b          <= digit_val;
                     digits     <= 3'd1;
                     state      <= S_ENTER_B;
                     fnd_serial <= digit_val;
                  end else if (is_op) begin
                     op         <= key_op;
                     fnd_serial <= op_code(key_op);
                  end
               end

               S_ENTER_B: begin
                  if (is_digit) begin
                     if (can_append) begin
                        b          <= b_append;
                        digits     <= digits + 3'd1;
                        fnd_serial <= b_append;
                     end
                  end else if (!is_op) begin
                     if (eval_ok) begin
                        res        <= eval_res32;
                        state      <= S_RESULT;
                        fnd_serial <= eval_res32;
                     end else begin
                        state      <= S_ERR;
                        fnd_serial <= CODE_ERR;
                        err        <= 1'b1;
                     end
                  end
               end

               S_RESULT: begin
                  if (is_digit) begin
                     a          <= digit_val;
                     digits     <= 3'd1;
                     state      <= S_ENTER_A;
                     fnd_serial <= digit_val;
                  end else if (is_op) begin
                     a          <= res;
                     op         <= key_op;
                     state      <= S_OP;
                     fnd_serial <= op_code(key_op);
                  end
               end

               S_ERR: begin
                  if (is_digit) begin
                     a          <= digit_val;
                     digits     <= 3'd1;
                     state      <= S_ENTER_A;
                     fnd_serial <= digit_val;
                     err        <= 1'b0;
                  end
               end

               default: begin
                  state      <= S_IDLE;
                  fnd_serial <= CODE_HAPPY;
                  err        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_calc_core.sv
// ============================================================================
// tb_calc_core : table-driven key sequences with an expected-display scoreboard
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_calc_core;

   logic               sw_clk;
   logic               rst;
   logic [4:0]         eBCD;
   logic signed [31:0] fnd_serial;
   logic               err;

   calc_core dut (
      .sw_clk     (sw_clk),
      .rst        (rst),
      .eBCD       (eBCD),
      .fnd_serial (fnd_serial),
      .err        (err)
   );

   initial sw_clk = 1'b0;
   always #5 sw_clk = ~sw_clk;

   localparam logic [31:0] HAPPY = 32'h00A0_0000;
   localparam logic [31:0] ERRC  = 32'h00EE_0000;
   localparam logic [31:0] PLUS  = 32'h0010_0000;
   localparam logic [31:0] MINUS = 32'h0020_0000;
   localparam logic [31:0] MULT  = 32'h0030_0000;
   localparam logic [31:0] DIVID = 32'h0040_0000;
   localparam logic [31:0] MODC  = 32'h0050_0000;
   localparam logic [4:0]  IDLE  = 5'h1F;

   typedef struct {
      logic [4:0]  key;
      int          hold;
      logic [31:0] fnd;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] fnd;
      logic        err;
   } exp_t;

   vec_t tbl1[$];
   vec_t tbl2[$];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic vec_t v(input logic [4:0] k, input int h, input int f, input logic e);
      vec_t r;
      r.key  = k;
      r.hold = h;
      r.fnd  = 32'(f);
      r.err  = e;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                    name, $signed(act), act, $signed(exp), exp);
   endtask

   // Drive one key press; the expectation is queued on drive and checked right after the event edge.
   task automatic press(input vec_t t, input string name);
      exp_t e;
      @(negedge sw_clk);
      eBCD = t.key;
      sb.push_back('{fnd: t.fnd, err: t.err});
      @(posedge sw_clk);
      #1;
      if (sb.size() == 0) begin
         check({name, " scoreboard"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, " fnd"}, fnd_serial, e.fnd);
         check({name, " err"}, {31'd0, err}, {31'd0, e.err});
      end
      repeat (t.hold - 1) @(posedge sw_clk);
      #1;
      check({name, " held"}, fnd_serial, t.fnd);
      @(negedge sw_clk);
      eBCD = IDLE;
      repeat (5) @(posedge sw_clk);
   endtask

   initial begin
      // 1 2 + (= ignored in OP, op replaced) 3 4 (* ignored in ENTER_B) = -> 46
      tbl1.push_back(v(5'd10, 3, HAPPY, 1'b0));
      tbl1.push_back(v(5'd15, 3, HAPPY, 1'b0));
      tbl1.push_back(v(5'd1,  3, 1, 1'b0));
      tbl1.push_back(v(5'd2,  3, 12, 1'b0));
      tbl1.push_back(v(5'd10, 3, PLUS, 1'b0));
      tbl1.push_back(v(5'd15, 3, PLUS, 1'b0));
      tbl1.push_back(v(5'd11, 3, MINUS, 1'b0));
      tbl1.push_back(v(5'd10, 3, PLUS, 1'b0));
      tbl1.push_back(v(5'd3,  3, 3, 1'b0));
      tbl1.push_back(v(5'd4,  3, 34, 1'b0));
      tbl1.push_back(v(5'd12, 3, 34, 1'b0));
      tbl1.push_back(v(5'd15, 3, 46, 1'b0));
      // 3 - 8 = -5, chained * 2 = -10
      tbl1.push_back(v(5'd3,  3, 3, 1'b0));
      tbl1.push_back(v(5'd11, 3, MINUS, 1'b0));
      tbl1.push_back(v(5'd8,  3, 8, 1'b0));
      tbl1.push_back(v(5'd15, 3, -5, 1'b0));
      tbl1.push_back(v(5'd12, 3, MULT, 1'b0));
      tbl1.push_back(v(5'd2,  3, 2, 1'b0));
      tbl1.push_back(v(5'd15, 3, -10, 1'b0));
      // 7 / 0 = -> error, then 5 recovers
      tbl1.push_back(v(5'd7,  3, 7, 1'b0));
      tbl1.push_back(v(5'd13, 3, DIVID, 1'b0));
      tbl1.push_back(v(5'd0,  3, 0, 1'b0));
      tbl1.push_back(v(5'd15, 3, ERRC, 1'b1));
      tbl1.push_back(v(5'd5,  3, 5, 1'b0));
      tbl1.push_back(v(5'd15, 3, 5, 1'b0));
      // seven 9s saturate at six digits, * 2 overflows
      tbl1.push_back(v(5'd9,  3, 9, 1'b0));
      tbl1.push_back(v(5'd9,  3, 99, 1'b0));
      tbl1.push_back(v(5'd9,  3, 999, 1'b0));
      tbl1.push_back(v(5'd9,  3, 9999, 1'b0));
      tbl1.push_back(v(5'd9,  3, 99999, 1'b0));
      tbl1.push_back(v(5'd9,  3, 999999, 1'b0));
      tbl1.push_back(v(5'd9,  3, 999999, 1'b0));
      tbl1.push_back(v(5'd12, 3, MULT, 1'b0));
      tbl1.push_back(v(5'd2,  3, 2, 1'b0));
      tbl1.push_back(v(5'd15, 3, ERRC, 1'b1));
      // long hold: one event only
      tbl1.push_back(v(5'd4,  20, 4, 1'b0));
      tbl1.push_back(v(5'd15, 3, 4, 1'b0));

      // 0 - 7 = -7, then % 3 = -1 (sign of dividend)
      tbl2.push_back(v(5'd0,  3, 0, 1'b0));
      tbl2.push_back(v(5'd11, 3, MINUS, 1'b0));
      tbl2.push_back(v(5'd7,  3, 7, 1'b0));
      tbl2.push_back(v(5'd15, 3, -7, 1'b0));
      tbl2.push_back(v(5'd14, 3, MODC, 1'b0));
      tbl2.push_back(v(5'd3,  3, 3, 1'b0));
      tbl2.push_back(v(5'd15, 3, -1, 1'b0));
      tbl2.push_back(v(5'd1,  3, 1, 1'b0));
      tbl2.push_back(v(5'd2,  3, 12, 1'b0));

      rst  = 1'b1;
      eBCD = IDLE;
      repeat (2) @(posedge sw_clk);
      #1;
      check("reset fnd", fnd_serial, HAPPY);
      check("reset err", {31'd0, err}, 32'd0);
      @(negedge sw_clk);
      rst = 1'b0;
      repeat (3) @(posedge sw_clk);

      for (int i = 0; i < tbl1.size(); i++)
         press(tbl1[i], $sformatf("tbl1[%0d] key %0d", i, tbl1[i].key));

      // From RESULT(4): 6 is an event, a direct 6->5 change is not
      @(negedge sw_clk);
      eBCD = 5'd6;
      @(posedge sw_clk);
      #1;
      check("key 6 event", fnd_serial, 32'd6);
      @(negedge sw_clk);
      eBCD = 5'd5;
      repeat (4) @(posedge sw_clk);
      #1;
      check("direct 6->5 no event", fnd_serial, 32'd6);
      @(negedge sw_clk);
      eBCD = IDLE;
      repeat (5) @(posedge sw_clk);
      press(v(5'd15, 3, 6, 1'b0), "equals after direct change");

      for (int i = 0; i < tbl2.size(); i++)
         press(tbl2[i], $sformatf("tbl2[%0d] key %0d", i, tbl2[i].key));

      // Reset mid-entry overrides a simultaneous key event
      @(negedge sw_clk);
      rst  = 1'b1;
      eBCD = 5'd3;
      @(posedge sw_clk);
      #1;
      check("mid-entry reset fnd", fnd_serial, HAPPY);
      check("mid-entry reset err", {31'd0, err}, 32'd0);
      @(negedge sw_clk);
      rst  = 1'b0;
      eBCD = IDLE;
      repeat (3) @(posedge sw_clk);
      press(v(5'd15, 3, HAPPY, 1'b0), "idle after reset eq");
      press(v(5'd12, 3, HAPPY, 1'b0), "idle after reset op");
      press(v(5'd8,  3, 8, 1'b0), "fresh operand after reset");

      check("scoreboard drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
